// File: rtl/traffic_light_ctrl.sv
// NS/EW intersection controller with configurable phase timing, all-red
// clearance, a latched pedestrian walk/clear phase and emergency preemption.
// Lamp outputs are decoded from registered state only.
//
// Handshake note: there are no valid/ready channels here. ped_req may be a
// pulse or a level and is latched. emerg_req is a level that is sampled every
// cycle, and emerg_dir is sampled together with it.
module traffic_light_ctrl #(
  parameter int CNT_W       = 8,
  parameter int NS_GREEN_T  = 20,
  parameter int EW_GREEN_T  = 16,
  parameter int YELLOW_T    = 4,
  parameter int ALL_RED_T   = 2,
  parameter int MIN_GREEN_T = 6,
  parameter int PED_WALK_T  = 10,
  parameter int PED_CLEAR_T = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       ped_green,
  output logic       ped_clear,
  output logic       ped_wait,
  output logic       emerg_active,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    NS_G, NS_Y, AR_NS, EW_G, EW_Y, AR_EW, PED_WALK, PED_CLEAR
  } state_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Last timer value of each phase: a phase of length T exits at timer == T-1.
  localparam logic [CNT_W-1:0] NS_G_LAST  = CNT_W'(NS_GREEN_T - 1);
  localparam logic [CNT_W-1:0] EW_G_LAST  = CNT_W'(EW_GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(PED_WALK_T - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(PED_CLEAR_T - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_q, ped_d;
  logic             next_dir_q, next_dir_d;
  logic             emerg_q, emerg_d;
  logic             hold;
  state_t           emerg_green;

  assign emerg_green = (emerg_dir == DIR_EW) ? EW_G : NS_G;

  // Register state, phase timer, pedestrian latch, post-walk direction and
  // the emergency-hold flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NS_G;
      timer_q    <= '0;
      ped_q      <= 1'b0;
      next_dir_q <= DIR_EW;
      emerg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_q      <= ped_d;
      next_dir_q <= next_dir_d;
      emerg_q    <= emerg_d;
    end
  end

  // Next-state, timer and latch update. Emergency is checked first, then
  // pedestrian service, then the normal rotation.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    hold       = 1'b0;
    case (state_q)
      NS_G: begin
        if (emerg_req) begin
          if (emerg_dir == DIR_EW) state_d = NS_Y;
          else                     hold    = 1'b1;
        end else if ((ped_q && timer_q >= MIN_LAST) || timer_q == NS_G_LAST) begin
          state_d = NS_Y;
        end
      end
      NS_Y:  if (timer_q == Y_LAST) state_d = AR_NS;
      AR_NS: begin
        if (timer_q == AR_LAST) begin
          if (emerg_req) begin
            state_d = emerg_green;
          end else if (ped_q) begin
            state_d    = PED_WALK;
            next_dir_d = DIR_EW;
          end else begin
            state_d = EW_G;
          end
        end
      end
      EW_G: begin
        if (emerg_req) begin
          if (emerg_dir == DIR_NS) state_d = EW_Y;
          else                     hold    = 1'b1;
        end else if ((ped_q && timer_q >= MIN_LAST) || timer_q == EW_G_LAST) begin
          state_d = EW_Y;
        end
      end
      EW_Y:  if (timer_q == Y_LAST) state_d = AR_EW;
      AR_EW: begin
        if (timer_q == AR_LAST) begin
          if (emerg_req) begin
            state_d = emerg_green;
          end else if (ped_q) begin
            state_d    = PED_WALK;
            next_dir_d = DIR_NS;
          end else begin
            state_d = NS_G;
          end
        end
      end
      PED_WALK: if (emerg_req || timer_q == WALK_LAST) state_d = PED_CLEAR;
      PED_CLEAR: begin
        if (timer_q == CLEAR_LAST) begin
          if (emerg_req)                 state_d = emerg_green;
          else if (next_dir_q == DIR_NS) state_d = NS_G;
          else                           state_d = EW_G;
        end
      end
      default: state_d = NS_G;
    endcase

    if (state_d != state_q) timer_d = '0;
    else if (hold)          timer_d = timer_q;
    else                    timer_d = timer_q + 1'b1;

    // Entering the walk phase serves the request, so clearing wins over a
    // press in that same cycle.
    ped_d = ped_q;
    if (state_d == PED_WALK && state_q != PED_WALK) ped_d = 1'b0;
    else if (ped_req && state_q != PED_WALK)        ped_d = 1'b1;

    // Flag the cycles in which the preempted green is being held.
    emerg_d = emerg_req && (state_d == emerg_green);
  end

  // Lamp and status decode from registered state.
  always_comb begin
    ns_green     = (state_q == NS_G);
    ns_yellow    = (state_q == NS_Y);
    ns_red       = !((state_q == NS_G) || (state_q == NS_Y));
    ew_green     = (state_q == EW_G);
    ew_yellow    = (state_q == EW_Y);
    ew_red       = !((state_q == EW_G) || (state_q == EW_Y));
    ped_green    = (state_q == PED_WALK);
    ped_clear    = (state_q == PED_CLEAR);
    ped_wait     = ped_q;
    emerg_active = emerg_q;
    state_dbg    = state_q;
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios with hand-derived phase
// timelines, then randomized traffic checked against a phase/age model.
module tb_traffic_light_ctrl;

  localparam int T_NSG  = 20;
  localparam int T_EWG  = 16;
  localparam int T_Y    = 4;
  localparam int T_AR   = 2;
  localparam int T_MIN  = 6;
  localparam int T_WALK = 10;
  localparam int T_CLR  = 6;

  localparam int PH_NSG  = 0;
  localparam int PH_NSY  = 1;
  localparam int PH_ARNS = 2;
  localparam int PH_EWG  = 3;
  localparam int PH_EWY  = 4;
  localparam int PH_AREW = 5;
  localparam int PH_WALK = 6;
  localparam int PH_CLR  = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req = 1'b0;
  logic       emerg_req = 1'b0;
  logic       emerg_dir = 1'b0;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       ped_green, ped_clear, ped_wait, emerg_active;
  logic [2:0] state_dbg;
  logic [9:0] dut_vec;

  int checks = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .emerg_req(emerg_req),
    .emerg_dir(emerg_dir), .ns_red(ns_red), .ns_yellow(ns_yellow),
    .ns_green(ns_green), .ew_red(ew_red), .ew_yellow(ew_yellow),
    .ew_green(ew_green), .ped_green(ped_green), .ped_clear(ped_clear),
    .ped_wait(ped_wait), .emerg_active(emerg_active), .state_dbg(state_dbg)
  );

  assign dut_vec = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                    ped_green, ped_clear, ped_wait, emerg_active};

  // Expected output vector for a phase, pending flag and emergency-hold flag.
  function automatic logic [9:0] exp_vec(int ph, bit w, bit a);
    bit nsg, nsy, ewg, ewy;
    nsg = (ph == PH_NSG); nsy = (ph == PH_NSY);
    ewg = (ph == PH_EWG); ewy = (ph == PH_EWY);
    return {!(nsg || nsy), nsy, nsg, !(ewg || ewy), ewy, ewg,
            ph == PH_WALK, ph == PH_CLR, w, a};
  endfunction

  // Phase of the undisturbed 48-cycle rotation at cycle c after reset.
  function automatic int normal_phase(int c);
    int m;
    m = c % (T_NSG + T_Y + T_AR + T_EWG + T_Y + T_AR);
    if (m < T_NSG)                          return PH_NSG;
    if (m < T_NSG + T_Y)                    return PH_NSY;
    if (m < T_NSG + T_Y + T_AR)             return PH_ARNS;
    if (m < T_NSG + T_Y + T_AR + T_EWG)     return PH_EWG;
    if (m < T_NSG + 2*T_Y + T_AR + T_EWG)   return PH_EWY;
    return PH_AREW;
  endfunction

  function automatic int phase_len(int ph);
    case (ph)
      PH_NSG:  return T_NSG;
      PH_EWG:  return T_EWG;
      PH_NSY, PH_EWY: return T_Y;
      PH_ARNS, PH_AREW: return T_AR;
      PH_WALK: return T_WALK;
      default: return T_CLR;
    endcase
  endfunction

  function automatic int green_of(bit d);
    return d ? PH_EWG : PH_NSG;
  endfunction

  // Reference model: current phase, cycles spent in it, pending request,
  // green to resume after a walk, and whether a preempted green is held.
  int m_phase, m_age;
  bit m_ped, m_after, m_shown;

  always @(posedge clk) begin
    int nxt;
    bit held, d;
    if (reset) begin
      m_phase <= PH_NSG; m_age <= 0; m_ped <= 0; m_after <= 1; m_shown <= 0;
    end else begin
      nxt = m_phase;
      held = 0;
      if (m_phase == PH_NSG || m_phase == PH_EWG) begin
        d = (m_phase == PH_EWG);
        if (emerg_req && emerg_dir != d) nxt = d ? PH_EWY : PH_NSY;
        else if (emerg_req) held = 1;
        else if ((m_ped && m_age + 1 >= T_MIN) || m_age + 1 == phase_len(m_phase))
          nxt = d ? PH_EWY : PH_NSY;
      end else if (m_phase == PH_NSY || m_phase == PH_EWY) begin
        if (m_age + 1 == T_Y) nxt = (m_phase == PH_NSY) ? PH_ARNS : PH_AREW;
      end else if (m_phase == PH_ARNS || m_phase == PH_AREW) begin
        d = (m_phase == PH_ARNS);
        if (m_age + 1 == T_AR) begin
          if (emerg_req) nxt = green_of(emerg_dir);
          else if (m_ped) begin nxt = PH_WALK; m_after <= d; end
          else nxt = green_of(d);
        end
      end else if (m_phase == PH_WALK) begin
        if (emerg_req || m_age + 1 == T_WALK) nxt = PH_CLR;
      end else begin
        if (m_age + 1 == T_CLR) nxt = emerg_req ? green_of(emerg_dir) : green_of(m_after);
      end
      if (nxt == PH_WALK && m_phase != PH_WALK) m_ped <= 0;
      else if (ped_req && m_phase != PH_WALK)   m_ped <= 1;
      m_shown <= emerg_req && (nxt == green_of(emerg_dir));
      m_age   <= (nxt != m_phase) ? 0 : (held ? m_age : m_age + 1);
      m_phase <= nxt;
    end
  end

  // Driver: reset for two edges, end at the negedge showing cycle 0.
  task automatic do_reset();
    reset = 1; ped_req = 0; emerg_req = 0; emerg_dir = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== exp_vec(PH_NSG, 0, 0)) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec, exp_vec(PH_NSG, 0, 0));
    end
    checks++;
    if (dut_vec !== exp_vec(m_phase, m_ped, m_shown)) begin
      failures++;
      $display("FAIL reset_model got=%b exp=%b", dut_vec, exp_vec(m_phase, m_ped, m_shown));
    end
  endtask

  task automatic test_normal_cycle();
    logic [9:0] e;
    do_reset();
    for (int c = 0; c < 96; c++) begin
      e = exp_vec(normal_phase(c), 0, 0);
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL normal_cycle c=%0d got=%b exp=%b", c, dut_vec, e);
      end
      @(negedge clk);
    end
  endtask

  // Pedestrian press at NS green cycle p shortens the green to
  // max(p+2, MIN) capped at the full green, then walk/clear, then EW green.
  task automatic test_ped_shorten(int p);
    int l, ph;
    logic [9:0] e;
    do_reset();
    l = (p + 2 < T_MIN) ? T_MIN : p + 2;
    if (l > T_NSG) l = T_NSG;
    for (int c = 0; c < l + 26; c++) begin
      ped_req = (c == p);
      if (c < l)               ph = PH_NSG;
      else if (c < l + 4)      ph = PH_NSY;
      else if (c < l + 6)      ph = PH_ARNS;
      else if (c < l + 16)     ph = PH_WALK;
      else if (c < l + 22)     ph = PH_CLR;
      else                     ph = PH_EWG;
      e = exp_vec(ph, (c > p) && (c < l + 6), 0);
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL ped_shorten p=%0d c=%0d got=%b exp=%b", p, c, dut_vec, e);
      end
      @(negedge clk);
    end
    ped_req = 0;
  endtask

  task automatic test_emergency();
    int ph;
    logic [9:0] e;
    do_reset();
    emerg_dir = 1;
    for (int c = 0; c < 71; c++) begin
      emerg_req = (c >= 3) && (c < 40);
      if (c < 4)       ph = PH_NSG;
      else if (c < 8)  ph = PH_NSY;
      else if (c < 10) ph = PH_ARNS;
      else if (c < 56) ph = PH_EWG;
      else if (c < 60) ph = PH_EWY;
      else if (c < 62) ph = PH_AREW;
      else             ph = PH_NSG;
      e = exp_vec(ph, 0, (c >= 10) && (c <= 40));
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL emergency c=%0d got=%b exp=%b", c, dut_vec, e);
      end
      @(negedge clk);
    end
    emerg_req = 0;
  endtask

  task automatic test_emerg_with_ped();
    int ph;
    logic [9:0] e;
    do_reset();
    emerg_dir = 1;
    for (int c = 0; c < 73; c++) begin
      ped_req   = (c == 1);
      emerg_req = (c >= 3) && (c < 40);
      if (c < 4)       ph = PH_NSG;
      else if (c < 8)  ph = PH_NSY;
      else if (c < 10) ph = PH_ARNS;
      else if (c < 46) ph = PH_EWG;
      else if (c < 50) ph = PH_EWY;
      else if (c < 52) ph = PH_AREW;
      else if (c < 62) ph = PH_WALK;
      else if (c < 68) ph = PH_CLR;
      else             ph = PH_NSG;
      e = exp_vec(ph, (c >= 2) && (c < 52), (c >= 10) && (c <= 40));
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL emerg_with_ped c=%0d got=%b exp=%b", c, dut_vec, e);
      end
      @(negedge clk);
    end
    ped_req = 0; emerg_req = 0;
  endtask

  task automatic test_reset_mid_walk();
    int ph;
    logic [9:0] e;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      ped_req = (c == 0) || (c == 16);
      reset   = (c == 16);
      if (c < 6)       ph = PH_NSG;
      else if (c < 10) ph = PH_NSY;
      else if (c < 12) ph = PH_ARNS;
      else             ph = PH_WALK;
      e = exp_vec(ph, (c >= 1) && (c < 12), 0);
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL reset_mid_walk_pre c=%0d got=%b exp=%b", c, dut_vec, e);
      end
      @(negedge clk);
    end
    reset = 0; ped_req = 0;
    for (int c = 0; c < 49; c++) begin
      e = exp_vec(normal_phase(c), 0, 0);
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL reset_mid_walk_post c=%0d got=%b exp=%b", c, dut_vec, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int emerg_left;
    logic [9:0] e;
    bit bad;
    do_reset();
    emerg_left = 0;
    for (int c = 0; c < 1500; c++) begin
      e = exp_vec(m_phase, m_ped, m_shown);
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL random_model c=%0d got=%b exp=%b", c, dut_vec, e);
      end
      bad = ((ns_green || ns_yellow) && (ew_green || ew_yellow)) ||
            (int'(ns_red) + int'(ns_yellow) + int'(ns_green) != 1) ||
            (int'(ew_red) + int'(ew_yellow) + int'(ew_green) != 1);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL random_invariant c=%0d got=%b exp=one_lamp_per_dir_no_conflict", c, dut_vec);
      end
      ped_req = ($urandom_range(0, 29) == 0);
      if (emerg_left > 0) begin
        emerg_left--;
        emerg_req = 1;
      end else begin
        emerg_req = 0;
        if ($urandom_range(0, 79) == 0) begin
          emerg_left = $urandom_range(1, 40);
          emerg_dir  = 1'($urandom_range(0, 1));
        end
      end
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 0; ped_req = 0; emerg_req = 0;
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_shorten(10);
    test_ped_shorten(0);
    test_ped_shorten($urandom_range(0, 19));
    test_emergency();
    test_emerg_with_ped();
    test_reset_mid_walk();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
